// File: rtl/alu32_issue_ctrl_if.sv
// rtl/alu32_issue_ctrl_if.sv - command, alu32 drive/sense and response signals of alu32_issue_ctrl
interface alu32_issue_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_cout;
  logic        alu_zout;
  logic        alu_ovf;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_out, alu_cout, alu_zout, alu_ovf,
    input  rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_flags
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_out, alu_cout, alu_zout, alu_ovf,
    output rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu32_issue_ctrl.sv
// rtl/alu32_issue_ctrl.sv - command FIFO plus settle/capture sequencer driving the alu32 ripple ALU
module alu32_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  alu32_issue_ctrl_if.slave bus,
  output logic              busy
);
  localparam int unsigned ENTRY_W  = 3 + 32 + 32;
  localparam logic [3:0]  CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];
  logic [31:0]          alu_a_q, alu_a_d;
  logic [31:0]          alu_b_q, alu_b_d;
  logic [2:0]           alu_op_q, alu_op_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_result_q, rsp_result_d;
  logic [2:0]           rsp_flags_q, rsp_flags_d;

  logic                 full, empty, push, pop;
  logic [ENTRY_W-1:0]   head;

  // Pointers are {wrap, index}: same index with different wrap means every slot is occupied.
  assign full  = (wr_ptr_q[0] == rd_ptr_q[0]) && (wr_ptr_q[1] != rd_ptr_q[1]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = bus.cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[0]];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    pop          = 1'b0;

    if (push) begin
      mem_d[wr_ptr_q[0]] = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
      wr_ptr_d           = wr_ptr_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        rsp_result_d = bus.alu_out;
        rsp_flags_d  = {bus.alu_ovf, bus.alu_cout, bus.alu_zout};
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Chain straight into the next command so streaming has no IDLE bubble.
          if (!empty) begin
            pop     = 1'b1;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      {alu_op_d, alu_a_d, alu_b_d} = head;
      cnt_d                        = CNT_INIT;
      rd_ptr_d                     = rd_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_q        <= '{default: '0};
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign busy           = (state_q != IDLE) || !empty;
endmodule
